window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen.sv | 184 ++++++++++++++++++
 tb/tb_window_3x3_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator: raster pixels pass through two line buffers into a
// 3x3 register window, and each complete window is handed to a sorter via start/valid.
//
//   state  | meaning
//   ACCEPT | taking pixels; a window-completing pixel moves to REQ
//   REQ    | window frozen, start_o high, waiting for sort_valid_i=1
//   REL    | window frozen, waiting for the sorter to drop sort_valid_i
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module window_3x3_gen #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [`BIT_WIDTH-1:0] pix_data_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic [`BIT_WIDTH-1:0] win_data0_o,
  output logic [`BIT_WIDTH-1:0] win_data1_o,
  output logic [`BIT_WIDTH-1:0] win_data2_o,
  output logic [`BIT_WIDTH-1:0] win_data3_o,
  output logic [`BIT_WIDTH-1:0] win_data4_o,
  output logic [`BIT_WIDTH-1:0] win_data5_o,
  output logic [`BIT_WIDTH-1:0] win_data6_o,
  output logic [`BIT_WIDTH-1:0] win_data7_o,
  output logic [`BIT_WIDTH-1:0] win_data8_o,
  output logic                  start_o,
  input  logic                  sort_valid_i,
  output logic                  frame_done_o
);

  localparam int BW = `BIT_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  if (IMG_WIDTH < 3) begin : g_bad_width
    $error("window_3x3_gen: IMG_WIDTH must be at least 3");
  end
  if (IMG_HEIGHT < 3) begin : g_bad_height
    $error("window_3x3_gen: IMG_HEIGHT must be at least 3");
  end

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_REQ    = 2'd1,
    ST_REL    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            last_q, last_d;
  logic            frame_done_q, frame_done_d;
  logic [BW-1:0]   lb1_q [IMG_WIDTH];
  logic [BW-1:0]   lb1_d [IMG_WIDTH];
  logic [BW-1:0]   lb2_q [IMG_WIDTH];
  logic [BW-1:0]   lb2_d [IMG_WIDTH];
  logic [BW-1:0]   win_q [9];
  logic [BW-1:0]   win_d [9];

  logic accept;
  logic win_complete;
  logic at_last_pix;

  assign accept       = pix_valid_i && (state_q == ST_ACCEPT);
  assign win_complete = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign at_last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // The oldest entry of lb1 is pixel(row-1,col) and of lb2 is pixel(row-2,col),
  // because each buffer holds exactly one row of accepts.
  always_comb begin
    lb1_d = lb1_q;
    lb2_d = lb2_q;
    win_d = win_q;
    if (accept) begin
      for (int i = IMG_WIDTH - 1; i > 0; i--) begin
        lb1_d[i] = lb1_q[i-1];
        lb2_d[i] = lb2_q[i-1];
      end
      lb1_d[0] = pix_data_i;
      lb2_d[0] = lb1_q[IMG_WIDTH-1];

      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_q[IMG_WIDTH-1];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_q[IMG_WIDTH-1];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (win_complete) begin
          state_d = ST_REQ;
          last_d  = at_last_pix;
        end
      end
      ST_REQ: begin
        if (sort_valid_i) begin
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (!sort_valid_i) begin
          state_d      = ST_ACCEPT;
          frame_done_d = last_q;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_ACCEPT;
      col_q        <= '0;
      row_q        <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      lb1_q        <= lb1_d;
      lb2_q        <= lb2_d;
      win_q        <= win_d;
    end
  end

  assign pix_ready_o  = (state_q == ST_ACCEPT);
  assign start_o      = (state_q == ST_REQ);
  assign frame_done_o = frame_done_q;

  assign win_data0_o = win_q[0];
  assign win_data1_o = win_q[1];
  assign win_data2_o = win_q[2];
  assign win_data3_o = win_q[3];
  assign win_data4_o = win_q[4];
  assign win_data5_o = win_q[5];
  assign win_data6_o = win_q[6];
  assign win_data7_o = win_q[7];
  assign win_data8_o = win_q[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen: frames of ramp and random pixels are
// streamed in, and every issued window is compared with one cut from the frame image.
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module tb_window_3x3_gen;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int BW   = `BIT_WIDTH;
  localparam int NPIX = W * H;
  localparam int WPF  = (W - 2) * (H - 2);

  logic          CLK = 1'b0;
  logic          RST;
  logic [BW-1:0] pix_data_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic [BW-1:0] win_data0_o, win_data1_o, win_data2_o, win_data3_o, win_data4_o;
  logic [BW-1:0] win_data5_o, win_data6_o, win_data7_o, win_data8_o;
  logic          start_o;
  logic          sort_valid_i;
  logic          frame_done_o;
  logic [9*BW-1:0] win_bus;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pix_data_i   (pix_data_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .win_data0_o  (win_data0_o),
    .win_data1_o  (win_data1_o),
    .win_data2_o  (win_data2_o),
    .win_data3_o  (win_data3_o),
    .win_data4_o  (win_data4_o),
    .win_data5_o  (win_data5_o),
    .win_data6_o  (win_data6_o),
    .win_data7_o  (win_data7_o),
    .win_data8_o  (win_data8_o),
    .start_o      (start_o),
    .sort_valid_i (sort_valid_i),
    .frame_done_o (frame_done_o)
  );

  assign win_bus = {win_data0_o, win_data1_o, win_data2_o, win_data3_o, win_data4_o,
                    win_data5_o, win_data6_o, win_data7_o, win_data8_o};

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: a frame image and the queue of windows it must produce.
  int              img [NPIX];
  logic [9*BW-1:0] exp_q [$];
  int              exp_fd = 0;

  task automatic push_windows();
    logic [9*BW-1:0] w;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        w = '0;
        for (int k = 0; k < 9; k++) begin
          w = {w[8*BW-1:0], BW'(img[(r - 1 + k / 3) * W + (c - 1 + k % 3)])};
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < NPIX; i++) img[i] = base + i;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, (1 << BW) - 1));
  endtask

  // Sorter stand-in: raises sort_valid_i sort_delay cycles after start_o,
  // drops it sort_hold cycles after start_o has fallen.
  int sort_delay = 3;
  int sort_hold  = 3;

  initial begin
    int s_cnt;
    sort_valid_i = 1'b0;
    s_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!sort_valid_i) begin
        if (start_o) begin
          s_cnt++;
          if (s_cnt >= sort_delay) begin
            sort_valid_i = 1'b1;
            s_cnt = 0;
          end
        end else begin
          s_cnt = 0;
        end
      end else if (!start_o) begin
        s_cnt++;
        if (s_cnt >= sort_hold) begin
          sort_valid_i = 1'b0;
          s_cnt = 0;
        end
      end
    end
  end

  // Monitor: sampled 1 time unit after each rising edge.
  int              win_cnt = 0;
  int              fd_cnt  = 0;
  logic            stall_en = 1'b0;
  int              stall_left = 0;

  initial begin
    logic            start_prev, fd_prev, holding;
    logic [9*BW-1:0] held;
    start_prev = 1'b0;
    fd_prev    = 1'b0;
    holding    = 1'b0;
    held       = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (start_o && !start_prev) begin
        win_cnt++;
        if (exp_q.size() == 0) chk("window_expected", 128'(exp_q.size() != 0), 128'd1);
        else chk("window", 128'(win_bus), 128'(exp_q.pop_front()));
        held    = win_bus;
        holding = 1'b1;
        if (stall_en) begin
          stall_left = 20;
          stall_en   = 1'b0;
        end
      end else if (holding && (start_o || sort_valid_i)) begin
        chk("win_hold", 128'(win_bus), 128'(held));
      end
      if (!start_o && !sort_valid_i) holding = 1'b0;
      if (start_o) chk("ready_in_req", 128'(pix_ready_o), 128'd0);
      if (sort_valid_i) begin
        chk("ready_in_rel", 128'(pix_ready_o), 128'd0);
        chk("start_in_rel", 128'(start_o), 128'd0);
      end
      if (stall_left > 0) begin
        chk("stall_start", 128'(start_o), 128'd1);
        chk("stall_ready", 128'(pix_ready_o), 128'd0);
        stall_left--;
      end
      if (frame_done_o) begin
        fd_cnt++;
        chk("fd_width", 128'(fd_prev), 128'd0);
      end
      fd_prev    = frame_done_o;
      start_prev = start_o;
    end
  end

  // Driver: entered and left on a falling edge.
  task automatic send_pixel(input int d);
    int   n;
    logic acc;
    pix_valid_i = 1'b1;
    pix_data_i  = BW'(d);
    n = 0;
    do begin
      acc = pix_ready_o;
      @(negedge CLK);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 128'(acc), 128'd1);
  endtask

  // gap < 0 picks a random idle gap of 0..2 cycles before each pixel.
  task automatic send_frame(input int gap, input int npix);
    int g;
    for (int i = 0; i < npix; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (g > 0) begin
        pix_valid_i = 1'b0;
        repeat (g) @(negedge CLK);
      end
      send_pixel(img[i]);
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !start_o && !sort_valid_i && pix_ready_o) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_timeout", 128'(n >= 1000), 128'd0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic run_frames(input string tag, input int gap, input int nframes, input int base);
    int w0, f0;
    w0 = win_cnt;
    f0 = fd_cnt;
    for (int f = 0; f < nframes; f++) begin
      if (base < 0) fill_rand();
      else fill_ramp(base + 100 * f);
      push_windows();
      send_frame(gap, NPIX);
      exp_fd++;
    end
    wait_idle();
    chk({tag, "_win_count"}, 128'(win_cnt - w0), 128'(WPF * nframes));
    chk({tag, "_fd_count"}, 128'(fd_cnt - f0), 128'(nframes));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST         = 1'b0;
    pix_valid_i = 1'b0;
    pix_data_i  = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 128'(pix_ready_o), 128'd1);
    chk("rst_start", 128'(start_o), 128'd0);
    chk("rst_fd", 128'(frame_done_o), 128'd0);
    chk("rst_win", 128'(win_bus), 128'd0);
    RST = 1'b1;
    @(negedge CLK);

    run_frames("ramp", 0, 1, 0);

    sort_delay = 25;
    stall_en   = 1'b1;
    run_frames("stall", 0, 1, 0);
    chk("stall_consumed", 128'(stall_en), 128'd0);
    sort_delay = 3;

    sort_hold = 6;
    run_frames("hold", 0, 1, 0);
    sort_hold = 3;

    run_frames("gaps", 2, 1, 0);

    // Reset while the first window of a frame is being requested.
    fill_ramp(0);
    push_windows();
    send_frame(0, 11);
    n = 0;
    while (!start_o && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("mid_req_reached", 128'(start_o), 128'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_start", 128'(start_o), 128'd0);
    chk("mid_rst_ready", 128'(pix_ready_o), 128'd1);
    chk("mid_rst_win", 128'(win_bus), 128'd0);
    @(negedge CLK);
    @(negedge CLK);
    exp_q.delete();
    RST = 1'b1;
    @(negedge CLK);
    run_frames("after_rst", 0, 1, 0);

    run_frames("b2b", 0, 2, 0);

    for (int t = 0; t < 6; t++) begin
      sort_delay = int'($urandom_range(1, 4));
      sort_hold  = int'($urandom_range(0, 4));
      run_frames("rand", -1, 2, -1);
    end

    chk("fd_total", 128'(fd_cnt), 128'(exp_fd));
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
